// File: rtl/pipe_trace_buffer_pkg.sv
// pipe_trace_pkg: state encoding and entry sizing shared by the trace buffer and its RAM.
package pipe_trace_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  function automatic int entry_w(input int data_w, input int num_probes);
    return (2 + num_probes) * data_w;
  endfunction
endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// trace_ram: simple dual-port trace storage, synchronous write, registered read with enable.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 224
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // write-through so the final capture is visible when readout starts on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: captures PC-change samples into a circular buffer, stops after a
// PC-match or halt, then drains the history oldest-first over a valid/ready port.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_PROBES  = 5,
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 8,
  parameter int POST_TRIG   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            pc_i,
  input  logic [DATA_W-1:0]            inst_i,
  input  logic [NUM_PROBES*DATA_W-1:0] probe_i,
  input  logic                         arm_i,
  input  logic                         trig_en_i,
  input  logic [DATA_W-1:0]            trig_pc_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [DATA_W-1:0]            rd_pc_o,
  output logic [DATA_W-1:0]            rd_inst_o,
  output logic [NUM_PROBES*DATA_W-1:0] rd_probe_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [1:0]                   state_o,
  output logic                         halted_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(DATA_W, NUM_PROBES);
  localparam int SW = $clog2(STALL_LIMIT) + 1;
  localparam int PW = $clog2(POST_TRIG + 1) + 1;

  state_t             state, state_n;
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]      count, count_n;
  logic [SW-1:0]      stall_cnt;
  logic [PW-1:0]      post_cnt;
  logic [DATA_W-1:0]  prev_pc;
  logic               prev_valid, rd_valid, halted;
  logic               arm_go, capture, same, wr, stall, halt, hit, post_done, full, xfer;
  logic [EW-1:0]      rdata;

  assign arm_go    = state == ST_IDLE && arm_i;
  assign capture   = state == ST_ARMED || state == ST_POST;
  assign same      = prev_valid && pc_i == prev_pc;
  assign wr        = capture && !same;
  assign stall     = capture && same;
  assign halt      = stall && stall_cnt == SW'(STALL_LIMIT - 2);
  assign hit       = state == ST_ARMED && wr && trig_en_i && pc_i == trig_pc_i;
  assign post_done = state == ST_POST && wr && post_cnt == PW'(1);
  assign full      = count == CW'(DEPTH);
  assign xfer      = state == ST_READOUT && rd_valid && rd_ready_i;

  // a full buffer drags rd_ptr along so the oldest entry is the one overwritten
  always_comb begin
    rd_ptr_n = arm_go ? '0 : ((wr && full) || xfer) ? rd_ptr + 1'b1 : rd_ptr;
    count_n  = arm_go ? '0 : (wr && !full) ? count + 1'b1 : xfer ? count - 1'b1 : count;
    state_n  = arm_go ? ST_ARMED :
               (halt || post_done || (hit && POST_TRIG == 0)) ? ST_READOUT :
               hit ? ST_POST :
               (state == ST_READOUT && count == '0) ? ST_IDLE : state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stall_cnt  <= '0;
      post_cnt   <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      rd_valid   <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state    <= state_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rd_valid <= state_n == ST_READOUT && count_n != '0;
      if (arm_go) begin
        wr_ptr     <= '0;
        prev_valid <= 1'b0;
        halted     <= 1'b0;
        stall_cnt  <= '0;
        post_cnt   <= '0;
      end
      if (wr) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev_pc    <= pc_i;
        prev_valid <= 1'b1;
        stall_cnt  <= '0;
      end else if (stall && stall_cnt != SW'(STALL_LIMIT - 1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (halt) halted <= 1'b1;
      if (hit) post_cnt <= PW'(POST_TRIG);
      else if (state == ST_POST && wr) post_cnt <= post_cnt - 1'b1;
    end
  end

  // read address looks one step ahead so the registered output tracks rd_ptr without bubbles
  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata ({pc_i, inst_i, probe_i}),
    .re    (state_n == ST_READOUT),
    .raddr (rd_ptr_n),
    .rdata (rdata)
  );

  assign rd_pc_o    = rdata[EW-1 -: DATA_W];
  assign rd_inst_o  = rdata[EW-DATA_W-1 -: DATA_W];
  assign rd_probe_o = rdata[NUM_PROBES*DATA_W-1:0];
  assign rd_valid_o = rd_valid;
  assign count_o    = count;
  assign state_o    = state;
  assign halted_o   = halted;
endmodule
